// File: rtl/mul_share_ctrl.sv
// Round-robin controller sharing one combinational array multiplier between two
// requesters: registers operands, waits a fixed settle time, returns the product.
module mul_share_ctrl #(
    parameter int M_W    = 2,
    parameter int Q_W    = 3,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [M_W-1:0]     req0_m,
    input  logic [Q_W-1:0]     req0_q,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [M_W-1:0]     req1_m,
    input  logic [Q_W-1:0]     req1_q,
    output logic [M_W-1:0]     mul_m,
    output logic [Q_W-1:0]     mul_q,
    input  logic [M_W+Q_W-1:0] mul_p,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [M_W+Q_W-1:0] rsp_p
);
    localparam int P_W   = M_W + Q_W;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic             last_grant_r;
    logic [M_W-1:0]   mul_m_r;
    logic [Q_W-1:0]   mul_q_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [P_W-1:0]   rsp_p_r;
    logic             gnt0_s;
    logic             gnt1_s;

    // Next-state decode and round-robin grant; a tie goes to the requester not served last
    always_comb begin
        state_nxt_s = state_r;
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    if (last_grant_r) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end else if (req0_valid) begin
                    gnt0_s = 1'b1;
                end else if (req1_valid) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                end
                if (gnt0_s || gnt1_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (count_r == CNT_ZERO) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Ready is gated by rst_n so nothing is accepted while reset is applied
    assign req0_ready = gnt0_s & rst_n;
    assign req1_ready = gnt1_s & rst_n;

    // State, operand, settle counter and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            count_r      <= CNT_ZERO;
            last_grant_r <= 1'b1;
            mul_m_r      <= {M_W{1'b0}};
            mul_q_r      <= {Q_W{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_p_r      <= {P_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (gnt0_s) begin
                        mul_m_r      <= req0_m;
                        mul_q_r      <= req0_q;
                        rsp_id_r     <= 1'b0;
                        last_grant_r <= 1'b0;
                        count_r      <= CNT_INIT;
                    end else if (gnt1_s) begin
                        mul_m_r      <= req1_m;
                        mul_q_r      <= req1_q;
                        rsp_id_r     <= 1'b1;
                        last_grant_r <= 1'b1;
                        count_r      <= CNT_INIT;
                    end else begin
                        count_r <= count_r;
                    end
                end
                WAIT: begin
                    if (count_r == CNT_ZERO) begin
                        rsp_p_r     <= mul_p;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        count_r <= count_r - CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mul_m     = mul_m_r;
    assign mul_q     = mul_q_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_p     = rsp_p_r;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: SETTLE=1 instance for traffic, SETTLE=3
// instance for the settle-time hold and latency check.
module tb_mul_share_ctrl;
    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_m, req1_m, mul_m;
    logic [2:0] req0_q, req1_q, mul_q;
    logic [4:0] mul_p, rsp_p;
    logic       rsp_valid, rsp_ready, rsp_id;

    logic       d3_req0_valid, d3_req0_ready, d3_req1_valid, d3_req1_ready;
    logic [1:0] d3_req0_m, d3_req1_m, d3_mul_m;
    logic [2:0] d3_req0_q, d3_req1_q, d3_mul_q;
    logic [4:0] d3_mul_p, d3_rsp_p;
    logic       d3_rsp_valid, d3_rsp_ready, d3_rsp_id;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic       rsp_valid_d = 1'b0;
    logic [5:0] exp_q[$];

    mul_share_ctrl #(.M_W(2), .Q_W(3), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m), .req0_q(req0_q),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m), .req1_q(req1_q),
        .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p)
    );

    mul_share_ctrl #(.M_W(2), .Q_W(3), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_m(d3_req0_m), .req0_q(d3_req0_q),
        .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready), .req1_m(d3_req1_m), .req1_q(d3_req1_q),
        .mul_m(d3_mul_m), .mul_q(d3_mul_q), .mul_p(d3_mul_p),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id), .rsp_p(d3_rsp_p)
    );

    function automatic logic [4:0] prod(input logic [1:0] m, input logic [2:0] q);
        logic [4:0] mm;
        logic [4:0] qq;
        mm = {3'b000, m};
        qq = {2'b00, q};
        return mm * qq;
    endfunction

    // Behavioural ripple-array multipliers
    assign mul_p    = prod(mul_m, mul_q);
    assign d3_mul_p = prod(d3_mul_m, d3_mul_q);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake
    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst_n) begin
            check("rdy_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
        end else begin
            if (req0_ready || req1_ready) begin
                check("rdy_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
                if (req0_ready && req0_valid) begin
                    exp_q.push_back({1'b0, prod(req0_m, req0_q)});
                    acc_cyc = cyc;
                end
                if (req1_ready && req1_valid) begin
                    exp_q.push_back({1'b1, prod(req1_m, req1_q)});
                    acc_cyc = cyc;
                end
            end
            if (rsp_valid && !rsp_valid_d) check("latency", cyc - acc_cyc, 32'd2);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, e[5]});
                    check("rsp_p", {27'd0, rsp_p}, {27'd0, e[4:0]});
                end
            end
        end
        rsp_valid_d = rsp_valid;
    end

    task automatic send(input int id, input logic [1:0] m, input logic [2:0] q);
        bit got;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_m = m; req0_q = q; req0_valid = 1'b1;
        end else begin
            req1_m = m; req1_q = q; req1_valid = 1'b1;
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) got = 1'b1;
        end
        check("send_accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
        end
        check("drain", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  prev;
        bit  got;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_m = 2'd1; req0_q = 3'd1;
        req1_valid = 1'b0; req1_m = 2'd0; req1_q = 3'd0;
        d3_req0_valid = 1'b0; d3_req0_m = 2'd0; d3_req0_q = 3'd0;
        d3_req1_valid = 1'b0; d3_req1_m = 2'd0; d3_req1_q = 3'd0;
        d3_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mul_m", {30'd0, mul_m}, 32'd0);
        check("rst_mul_q", {29'd0, mul_q}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_rsp_p", {27'd0, rsp_p}, 32'd0);

        // Simultaneous requests: 0 first after reset, then alternate, spaced SETTLE+2
        @(posedge clk); #1;
        req0_m = 2'd2; req0_q = 3'd5; req1_m = 2'd3; req1_q = 3'd6;
        req0_valid = 1'b1; req1_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) got = 1'b1;
            end
            check("arb_seen", {31'd0, got}, 32'd1);
            check("arb_order", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) check("arb_spacing", cyc - prev, 32'd3);
            prev = cyc;
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();

        // Single request, largest operands
        send(0, 2'd3, 3'd7);
        wait_drain();

        // Backpressure: response held, nobody granted
        rsp_ready = 1'b0;
        send(0, 2'd1, 3'd3);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check("bp_valid_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1 req1_m = 2'd2; req1_q = 3'd2; req1_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_hold_p", {27'd0, rsp_p}, 32'd3);
            check("bp_hold_id", {31'd0, rsp_id}, 32'd0);
            check("bp_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req1_ready) got = 1'b1;
        end
        check("bp_next_grant", {31'd0, got}, 32'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_drain();

        // Reset during WAIT abandons the request
        send(0, 2'd2, 3'd3);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
            check("mid_rst_mul_m", {30'd0, mul_m}, 32'd0);
            check("mid_rst_mul_q", {29'd0, mul_q}, 32'd0);
        end
        send(1, 2'd3, 3'd7);
        wait_drain();

        // Back-to-back zero operands from one requester
        @(posedge clk); #1 req0_m = 2'd0; req0_q = 3'd0; req0_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                if (req0_ready) got = 1'b1;
            end
            check("b2b_seen", {31'd0, got}, 32'd1);
            if (k > 0) check("b2b_spacing", cyc - prev, 32'd3);
            prev = cyc;
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_drain();

        // SETTLE=3: operands held for three WAIT cycles, product four cycles after accept
        do_reset();
        @(posedge clk); #1 d3_req0_m = 2'd1; d3_req0_q = 3'd4; d3_req0_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (d3_req0_ready) got = 1'b1;
        end
        check("s3_accept", {31'd0, got}, 32'd1);
        prev = cyc;
        @(posedge clk); #1 d3_req0_valid = 1'b0; d3_req0_m = 2'd2; d3_req0_q = 3'd1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("s3_hold_m", {30'd0, d3_mul_m}, 32'd1);
            check("s3_hold_q", {29'd0, d3_mul_q}, 32'd4);
            check("s3_not_valid", {31'd0, d3_rsp_valid}, 32'd0);
        end
        @(negedge clk);
        check("s3_valid", {31'd0, d3_rsp_valid}, 32'd1);
        check("s3_latency", cyc - prev, 32'd4);
        check("s3_p", {27'd0, d3_rsp_p}, 32'd4);
        check("s3_id", {31'd0, d3_rsp_id}, 32'd0);
        repeat (2) @(negedge clk);
        check("s3_done", {31'd0, d3_rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Sequencing and arbitration controller that shares one combinational array multiplier (default 2x3 bits, 5-bit product) between two requesters. It arbitrates round-robin and registers the winner's operands onto the multiplier inputs. It waits a fixed settle time for the ripple array, then captures the product and returns it with the requester ID over a valid/ready response channel. It sits between the requesting logic and the multiplier instance in the FPGA datapath.

Parameters:
M_W, 2, width of multiplicand m
Q_W, 3, width of multiplier q
SETTLE, 1, cycles operands are held on the array before product capture; legal range 1..15

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 operands accepted this cycle
req0_m  in  M_W  requester 0 multiplicand
req0_q  in  Q_W  requester 0 multiplier
req1_valid  in  1  requester 1 has operands
req1_ready  out  1  requester 1 operands accepted this cycle
req1_m  in  M_W  requester 1 multiplicand
req1_q  in  Q_W  requester 1 multiplier
mul_m  out  M_W  registered operand to multiplier m input
mul_q  out  Q_W  registered operand to multiplier q input
mul_p  in  M_W+Q_W  product from multiplier
rsp_valid  out  1  response holds a product
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_p  out  M_W+Q_W  captured product

Behaviour:
- Reset applies on a clk edge with rst_n=0. It forces state=IDLE, mul_m=0, mul_q=0, rsp_valid=0, rsp_id=0, rsp_p=0, count=0, and last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation abandons the in-flight request. No response is produced for it.
- req0_ready and req1_ready are combinational from state, valid, and last_grant. They are 1 only in IDLE, at most one per cycle, and always 0 during reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, neither valid: stay in IDLE.
- IDLE, one valid: grant that requester.
- IDLE, both valid: grant the requester != last_grant.
- On grant:
  - assert its ready;
  - on the edge, register its m/q into mul_m/mul_q, its index into rsp_id and last_grant;
  - set count=SETTLE-1 and go to WAIT.
- WAIT:
  - mul_m/mul_q are held constant.
  - If count!=0, decrement.
  - If count==0, on the edge register mul_p into rsp_p, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, and rsp_p are held stable until rsp_ready=1.
  - On the edge with rsp_ready=1, clear rsp_valid and go to IDLE. rsp_p and rsp_id keep their last value.
  - No new grant is made in RESP.
- Latency: accept edge at cycle N; rsp_valid=1 from cycle N+1+SETTLE.
- Minimum request-to-request spacing is SETTLE+2 cycles, with rsp_ready tied to 1.
- mul_m/mul_q keep the last operands while IDLE; they change only on grant.
- Arithmetic: the product is unsigned, width M_W+Q_W, and is not truncated. The controller does not check mul_p.
- A requester that drops valid before it is granted is simply not granted. A requester that holds valid while the other is served is granted next (fairness).

Test Plan:
- Reset then single request: req0 m=3, q=7 -> req0_ready=1 for 1 cycle; rsp_valid rises 2 cycles after accept (SETTLE=1), rsp_id=0, rsp_p=21.
- Simultaneous requests: req0 (2,5) and req1 (3,6) both held valid -> req0 served first with rsp_p=10, id=0; then req1 with rsp_p=18, id=1; then req0 again if still valid.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id, and rsp_p held stable; no ready to any requester until acceptance.
- SETTLE=3 with m=1, q=4 -> mul_m/mul_q stable for 3 WAIT cycles; rsp_p=4 exactly 4 cycles after the accept edge.
- Reset mid-WAIT with rst_n=0 for 1 cycle -> next cycle state IDLE, rsp_valid=0, mul_m=mul_q=0; a following req1 (3,7) yields rsp_p=21, id=1, with no stale response.
- Extremes: (0,0) -> 0; (3,7) -> 21. Back-to-back with rsp_ready=1 -> accepts spaced exactly SETTLE+2 cycles.
